regfile_write_sequencer: RTL and testbench

- Owns the single write port of the 32x32 register file.
- After reset, or on request, it runs an initialisation sweep that writes every register with (index + INIT_OFFSET).
- In normal operation it arbitrates two valid/ready write requesters (A = ALU writeback, B = load/debug writeback) onto that port, round-robin.
- It sits between the writeback stage and the register file; the register file then needs no reset loop of its own.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/rr_arbiter2.sv | 35 +++
 rtl/regfile_write_sequencer.sv | 113 +++++++++++
 tb/tb_regfile_write_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write sequencer.
// Optional macro REGFILE_ZERO_LOCK_EN hard-wires register 0 to zero.
package regfile_pkg;

    localparam int unsigned NUM_REGS    = 32;
    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned INIT_OFFSET = 1;

    // One extra bit so the sweep counter can reach NUM_REGS without wrapping
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {INIT, RUN} seq_state_t;
    typedef enum logic {REQ_A, REQ_B} req_sel_t;

    function automatic logic [DATA_W-1:0] init_value(input logic [CNT_W-1:0] idx);
        logic [DATA_W-1:0] v;
        v = DATA_W'(idx) + DATA_W'(INIT_OFFSET);
`ifdef REGFILE_ZERO_LOCK_EN
        if (idx == '0) begin
            v = '0;
        end
`endif
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer moves to the other side after every grant.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] Req,
    input  logic       Enable,
    output logic [1:0] Grant
);

    req_sel_t ptr;

    always_comb begin
        Grant = 2'b00;
        if (Enable) begin
            if (Req == 2'b11) begin
                Grant = (ptr == REQ_A) ? 2'b01 : 2'b10;
            end else begin
                Grant = Req;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr <= REQ_A;
        end else if (Grant[0]) begin
            ptr <= REQ_B;
        end else if (Grant[1]) begin
            ptr <= REQ_A;
        end
    end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Owns the register-file write port: init sweep after reset/request, then round-robin writeback.
// Optional macro REGFILE_ZERO_LOCK_EN suppresses all writes to register 0.
module regfile_write_sequencer
    import regfile_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Init_Start,
    input  logic              A_Valid,
    output logic              A_Ready,
    input  logic [ADDR_W-1:0] A_Reg_Num,
    input  logic [DATA_W-1:0] A_Data,
    input  logic              B_Valid,
    output logic              B_Ready,
    input  logic [ADDR_W-1:0] B_Reg_Num,
    input  logic [DATA_W-1:0] B_Data,
    output logic              Reg_Write,
    output logic [ADDR_W-1:0] Write_Reg_Num,
    output logic [DATA_W-1:0] Write_Data,
    output logic              Busy,
    output logic              Init_Done
);

    seq_state_t        state;
    logic [CNT_W-1:0]  counter;
    logic [1:0]        grant;
    logic              arb_enable;
    logic              xfer;
    logic              write_allowed;
    logic [ADDR_W-1:0] sel_num;
    logic [DATA_W-1:0] sel_data;

    assign arb_enable = (state == RUN) && !Init_Start && !Reset;

    rr_arbiter2 u_arb (
        .Clk    (Clk),
        .Reset  (Reset),
        .Req    ({B_Valid, A_Valid}),
        .Enable (arb_enable),
        .Grant  (grant)
    );

    assign A_Ready = grant[0];
    assign B_Ready = grant[1];
    assign xfer    = grant[0] | grant[1];

    always_comb begin
        sel_num  = A_Reg_Num;
        sel_data = A_Data;
        if (grant[1]) begin
            sel_num  = B_Reg_Num;
            sel_data = B_Data;
        end
    end

`ifdef REGFILE_ZERO_LOCK_EN
    // Writes to r0 still handshake, they just never reach the port
    assign write_allowed = (sel_num != '0);
`else
    assign write_allowed = 1'b1;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= INIT;
            counter       <= '0;
            Reg_Write     <= 1'b0;
            Write_Reg_Num <= '0;
            Write_Data    <= '0;
            Busy          <= 1'b1;
            Init_Done     <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (Init_Start) begin
                        counter   <= '0;
                        Reg_Write <= 1'b0;
                    end else if (counter < CNT_W'(NUM_REGS)) begin
                        Reg_Write     <= 1'b1;
                        Write_Reg_Num <= counter[ADDR_W-1:0];
                        Write_Data    <= init_value(counter);
                        counter       <= counter + 1'b1;
                    end else begin
                        // Last sweep write is on the port this cycle; hand over next cycle
                        Reg_Write <= 1'b0;
                        state     <= RUN;
                        Busy      <= 1'b0;
                        Init_Done <= 1'b1;
                    end
                end
                RUN: begin
                    if (Init_Start) begin
                        state     <= INIT;
                        counter   <= '0;
                        Reg_Write <= 1'b0;
                        Busy      <= 1'b1;
                        Init_Done <= 1'b0;
                    end else begin
                        Reg_Write <= xfer && write_allowed;
                        if (xfer) begin
                            Write_Reg_Num <= sel_num;
                            Write_Data    <= sel_data;
                        end
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Randomized bench for regfile_write_sequencer against a cycle-level behavioural model.
module tb_regfile_write_sequencer;
    import regfile_pkg::*;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Init_Start;
    logic              A_Valid;
    logic              A_Ready;
    logic [ADDR_W-1:0] A_Reg_Num;
    logic [DATA_W-1:0] A_Data;
    logic              B_Valid;
    logic              B_Ready;
    logic [ADDR_W-1:0] B_Reg_Num;
    logic [DATA_W-1:0] B_Data;
    logic              Reg_Write;
    logic [ADDR_W-1:0] Write_Reg_Num;
    logic [DATA_W-1:0] Write_Data;
    logic              Busy;
    logic              Init_Done;

    always #5 Clk = ~Clk;

    regfile_write_sequencer dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Init_Start    (Init_Start),
        .A_Valid       (A_Valid),
        .A_Ready       (A_Ready),
        .A_Reg_Num     (A_Reg_Num),
        .A_Data        (A_Data),
        .B_Valid       (B_Valid),
        .B_Ready       (B_Ready),
        .B_Reg_Num     (B_Reg_Num),
        .B_Data        (B_Data),
        .Reg_Write     (Reg_Write),
        .Write_Reg_Num (Write_Reg_Num),
        .Write_Data    (Write_Data),
        .Busy          (Busy),
        .Init_Done     (Init_Done)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model state: what the port and status flags should show this cycle
    bit          m_init;
    int          m_idx;
    bit          m_ptr_b;
    bit          m_we;
    int          m_num;
    logic [31:0] m_data;
    bit          m_busy;
    bit          m_done;
    bit          a_acc;
    bit          b_acc;

    logic [DATA_W-1:0] rf_dut [NUM_REGS];
    logic [DATA_W-1:0] rf_exp [NUM_REGS];

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit zero_locked(input int r);
`ifdef REGFILE_ZERO_LOCK_EN
        return r == 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] sweep_val(input int i);
        if (zero_locked(i)) return '0;
        return DATA_W'(i + INIT_OFFSET);
    endfunction

    task automatic model_reset();
        m_init  = 1'b1;
        m_idx   = 0;
        m_ptr_b = 1'b0;
        m_we    = 1'b0;
        m_num   = 0;
        m_data  = '0;
        m_busy  = 1'b1;
        m_done  = 1'b0;
    endtask

    // Check one cycle at the falling edge, then advance the model across the rising edge
    task automatic cycle();
        bit en;
        @(negedge Clk);
        en    = !m_init && !Init_Start && !Reset;
        a_acc = en && A_Valid && (!B_Valid || !m_ptr_b);
        b_acc = en && B_Valid && (!A_Valid || m_ptr_b);
        check("a_ready", {31'b0, A_Ready}, {31'b0, a_acc});
        check("b_ready", {31'b0, B_Ready}, {31'b0, b_acc});
        check("reg_write", {31'b0, Reg_Write}, {31'b0, m_we});
        if (m_we) begin
            check("write_reg_num", {27'b0, Write_Reg_Num}, DATA_W'(m_num));
            check("write_data", Write_Data, m_data);
        end
        check("busy", {31'b0, Busy}, {31'b0, m_busy});
        check("init_done", {31'b0, Init_Done}, {31'b0, m_done});
        if (Reg_Write === 1'b1) rf_dut[Write_Reg_Num] = Write_Data;
        if (m_we) rf_exp[m_num] = m_data;

        if (Reset) begin
            model_reset();
        end else if (m_init) begin
            if (Init_Start) begin
                m_idx = 0;
                m_we  = 1'b0;
            end else if (m_idx < NUM_REGS) begin
                m_we   = 1'b1;
                m_num  = m_idx;
                m_data = sweep_val(m_idx);
                m_idx++;
            end else begin
                m_we   = 1'b0;
                m_init = 1'b0;
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (Init_Start) begin
            m_init = 1'b1;
            m_idx  = 0;
            m_we   = 1'b0;
            m_busy = 1'b1;
            m_done = 1'b0;
        end else if (a_acc || b_acc) begin
            m_num   = a_acc ? int'(A_Reg_Num) : int'(B_Reg_Num);
            m_data  = a_acc ? A_Data : B_Data;
            m_we    = !zero_locked(m_num);
            m_ptr_b = a_acc;
        end else begin
            m_we = 1'b0;
        end
        @(posedge Clk);
        #1;
    endtask

    // New random requests, but an unaccepted request is held unchanged
    task automatic drive_random();
        if (!(A_Valid && !a_acc)) begin
            A_Valid   = 1'($urandom_range(0, 1));
            A_Reg_Num = ADDR_W'($urandom);
            A_Data    = $urandom;
        end
        if (!(B_Valid && !b_acc)) begin
            B_Valid   = 1'($urandom_range(0, 1));
            B_Reg_Num = ADDR_W'($urandom);
            B_Data    = $urandom;
        end
    endtask

    initial begin
        Reset      = 1'b1;
        Init_Start = 1'b0;
        A_Valid    = 1'b0;
        B_Valid    = 1'b0;
        A_Reg_Num  = '0;
        B_Reg_Num  = '0;
        A_Data     = '0;
        B_Data     = '0;
        a_acc      = 1'b0;
        b_acc      = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rf_dut[i] = '0;
            rf_exp[i] = '0;
        end
        model_reset();
        @(posedge Clk);
        #1;
        repeat (2) cycle();

        // Initial sweep with requesters knocking; none may be accepted
        Reset = 1'b0;
        repeat (34) begin
            drive_random();
            cycle();
        end

        // Contention: expect A,B,A,B
        A_Valid = 1'b1; A_Reg_Num = 5'd3; A_Data = 32'h11;
        B_Valid = 1'b1; B_Reg_Num = 5'd4; B_Data = 32'h22;
        repeat (4) cycle();
        A_Valid = 1'b0;
        B_Valid = 1'b0;
        cycle();

        // B alone, back-to-back
        for (int i = 0; i < 3; i++) begin
            B_Valid   = 1'b1;
            B_Reg_Num = ADDR_W'(5 + i);
            B_Data    = $urandom;
            cycle();
        end
        B_Valid = 1'b0;
        cycle();

        // Accepted write completes across an Init_Start; A held through the sweep
        A_Valid = 1'b1; A_Reg_Num = 5'd9; A_Data = 32'hAB;
        cycle();
        Init_Start = 1'b1;
        cycle();
        Init_Start = 1'b0;
        repeat (34) cycle();
        A_Valid = 1'b0;
        cycle();

        // Write targeting r0
        A_Valid = 1'b1; A_Reg_Num = 5'd0; A_Data = 32'h5A;
        cycle();
        A_Valid = 1'b0;
        repeat (2) cycle();

        // Reset in the middle of a sweep (counter = 10)
        Init_Start = 1'b1;
        cycle();
        Init_Start = 1'b0;
        repeat (10) cycle();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        repeat (36) cycle();

        // Random traffic with occasional re-init and reset
        repeat (400) begin
            drive_random();
            Init_Start = ($urandom_range(0, 99) == 0);
            Reset      = ($urandom_range(0, 199) == 0);
            cycle();
        end
        Init_Start = 1'b0;
        Reset      = 1'b0;
        A_Valid    = 1'b0;
        B_Valid    = 1'b0;
        repeat (40) cycle();

        for (int i = 0; i < NUM_REGS; i++) begin
            check($sformatf("rf[%0d]", i), rf_dut[i], rf_exp[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
